// File: rtl/reservation_station_if.sv
// Entry formats shared by rename, the reservation stations and the FUs, plus the
// dispatch/issue bundle between the dispatch stage (master) and a station (slave).

localparam int RS_PREG_W = 7;
localparam int RS_ROB_W  = 5;

typedef struct packed {
    logic [6:0]           opcode;
    logic [9:0]           funct;
    logic [31:0]          imm;
    logic [RS_PREG_W-1:0] pd_old;
} rs_payload_t;

typedef struct packed {
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic [RS_PREG_W-1:0] pd_new;
    logic [1:0]           fu;
    rs_payload_t          payload;
} rename_data_t;

typedef struct packed {
    logic                 valid;
    logic [RS_ROB_W-1:0]  rob_index;
    logic [RS_PREG_W-1:0] pd;
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic                 ps1_rdy;
    logic                 ps2_rdy;
    logic [1:0]           fu;
    rs_payload_t          payload;
} rs_data_t;

interface reservation_station_if;
    rename_data_t        r_data;
    logic [RS_ROB_W-1:0] rob_index_in;
    logic                di_en;
    logic                full;
    logic                fu_ready;
    logic                fu_dispatched;
    rs_data_t            data_out;

    modport master (
        output r_data, rob_index_in, di_en, fu_ready,
        input  full, fu_dispatched, data_out
    );

    modport slave (
        input  r_data, rob_index_in, di_en, fu_ready,
        output full, fu_dispatched, data_out
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds renamed instructions until both sources are ready,
// issues the oldest ready one per cycle and drops entries younger than a mispredict.

module reservation_station #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = RS_PREG_W,
    parameter int ROB_W  = RS_ROB_W
) (
    input  logic                  clk,
    input  logic                  reset,
    reservation_station_if.slave  rs,
    input  logic                  mispredict,
    input  logic [ROB_W-1:0]      mispredict_tag,
    input  logic [PREG_W-1:0]     ps_in,
    input  logic                  ps_ready,
    input  logic                  preg_rtable [2**PREG_W]
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] rdy1_reg;
    logic [DEPTH-1:0] rdy2_reg;
    logic [ROB_W-1:0] tag_reg   [DEPTH];
    rename_data_t     entry_reg [DEPTH];
    // older_reg[i][j] = 1 when entry i was allocated before entry j
    logic [DEPTH-1:0] older_reg [DEPTH];

    rs_data_t         data_out_reg;
    logic             fu_dispatched_reg;

    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;
    logic [DEPTH-1:0] eff1;
    logic [DEPTH-1:0] eff2;
    logic [DEPTH-1:0] younger;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] pick;

    logic             full_c;
    logic             alloc_en;
    logic             issue_en;
    logic             alloc_wake1;
    logic             alloc_wake2;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] issue_idx;
    logic [ROB_W-1:0] rel_tail;
    rs_data_t         issue_data;

    assign full_c   = &valid_reg;
    assign alloc_en = rs.di_en && !full_c && !mispredict;
    assign rel_tail = rs.rob_index_in - mispredict_tag;

    assign alloc_wake1 = preg_rtable[rs.r_data.ps1] || (ps_ready && (ps_in == rs.r_data.ps1));
    assign alloc_wake2 = preg_rtable[rs.r_data.ps2] || (ps_ready && (ps_in == rs.r_data.ps2));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ROB_W-1:0] rel_tag;
            logic [DEPTH-1:0] older_than_me;

            // Distances from the branch along the circular ROB decide who is younger.
            assign rel_tag     = tag_reg[gi] - mispredict_tag;
            assign younger[gi] = mispredict && valid_reg[gi] &&
                                 (tag_reg[gi] != mispredict_tag) && (rel_tag < rel_tail);

            assign wake1[gi] = preg_rtable[entry_reg[gi].ps1] ||
                               (ps_ready && (ps_in == entry_reg[gi].ps1));
            assign wake2[gi] = preg_rtable[entry_reg[gi].ps2] ||
                               (ps_ready && (ps_in == entry_reg[gi].ps2));

            // Wakeup is bypassed into select so a broadcast this cycle can issue at the next edge.
            assign eff1[gi] = rdy1_reg[gi] || wake1[gi];
            assign eff2[gi] = rdy2_reg[gi] || wake2[gi];
            assign cand[gi] = rs.fu_ready && valid_reg[gi] && eff1[gi] && eff2[gi] && !younger[gi];

            always_comb begin
                older_than_me = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_than_me[j] = older_reg[j][gi];
                end
            end

            assign pick[gi] = cand[gi] && ((cand & older_than_me) == '0);
        end
    endgenerate

    assign issue_en = |pick;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) alloc_idx = IDX_W'(i);
        end
        issue_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pick[i]) issue_idx = IDX_W'(i);
        end
    end

    always_comb begin
        issue_data           = '0;
        issue_data.valid     = 1'b1;
        issue_data.rob_index = tag_reg[issue_idx];
        issue_data.pd        = entry_reg[issue_idx].pd_new;
        issue_data.ps1       = entry_reg[issue_idx].ps1;
        issue_data.ps2       = entry_reg[issue_idx].ps2;
        issue_data.ps1_rdy   = 1'b1;
        issue_data.ps2_rdy   = 1'b1;
        issue_data.fu        = entry_reg[issue_idx].fu;
        issue_data.payload   = entry_reg[issue_idx].payload;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
            rdy1_reg  <= '0;
            rdy2_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_reg[i]   <= '0;
                entry_reg[i] <= '0;
                older_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_en && (alloc_idx == IDX_W'(i))) begin
                    valid_reg[i] <= 1'b1;
                    entry_reg[i] <= rs.r_data;
                    tag_reg[i]   <= rs.rob_index_in;
                    rdy1_reg[i]  <= alloc_wake1;
                    rdy2_reg[i]  <= alloc_wake2;
                    older_reg[i] <= '0;
                end else begin
                    if (younger[i] || (issue_en && (issue_idx == IDX_W'(i)))) begin
                        valid_reg[i] <= 1'b0;
                    end
                    rdy1_reg[i] <= eff1[i];
                    rdy2_reg[i] <= eff2[i];
                    // Every resident entry is older than the one being allocated.
                    if (alloc_en) older_reg[i][alloc_idx] <= valid_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg      <= '0;
            fu_dispatched_reg <= 1'b0;
        end else if (issue_en) begin
            data_out_reg      <= issue_data;
            fu_dispatched_reg <= 1'b1;
        end else begin
            data_out_reg      <= '0;
            fu_dispatched_reg <= 1'b0;
        end
    end

    assign rs.full          = full_c;
    assign rs.data_out      = data_out_reg;
    assign rs.fu_dispatched = fu_dispatched_reg;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus a random run, all checked
// against an age-ordered queue model of the station.

module tb_reservation_station;
    localparam int DEPTH = 8;

    typedef struct {
        logic [4:0]   tag;
        rename_data_t d;
        bit           r1;
        bit           r2;
    } m_entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mispredict = 1'b0;
    logic [4:0] mispredict_tag = '0;
    logic [6:0] ps_in = '0;
    logic       ps_ready = 1'b0;
    logic       tbl [128];

    reservation_station_if rs_if();

    reservation_station #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs             (rs_if),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .ps_in          (ps_in),
        .ps_ready       (ps_ready),
        .preg_rtable    (tbl)
    );

    always #5 clk = ~clk;

    int       errors = 0;
    int       checks = 0;
    m_entry_t mq[$];
    bit       exp_disp;
    rs_data_t exp_out;

    function automatic rename_data_t mk(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd);
        rename_data_t r;
        r.ps1            = p1;
        r.ps2            = p2;
        r.pd_new         = pd;
        r.fu             = 2'($urandom);
        r.payload.opcode = 7'($urandom);
        r.payload.funct  = 10'($urandom);
        r.payload.imm    = $urandom;
        r.payload.pd_old = 7'($urandom);
        return r;
    endfunction

    function automatic bit is_younger(input logic [4:0] t, input logic [4:0] bt, input logic [4:0] tail);
        int dt;
        int dtail;
        dt    = (int'(t) - int'(bt) + 32) % 32;
        dtail = (int'(tail) - int'(bt) + 32) % 32;
        return (t != bt) && (dt < dtail);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied, then clock the DUT.
    task automatic step();
        int       sel;
        bit       was_full;
        m_entry_t e;
        sel      = -1;
        was_full = (mq.size() == DEPTH);
        for (int i = 0; i < mq.size(); i++) begin
            e    = mq[i];
            e.r1 = e.r1 || tbl[e.d.ps1] || (ps_ready && ps_in == e.d.ps1);
            e.r2 = e.r2 || tbl[e.d.ps2] || (ps_ready && ps_in == e.d.ps2);
            mq[i] = e;
        end
        if (rs_if.fu_ready) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1 && mq[i].r2 &&
                    !(mispredict && is_younger(mq[i].tag, mispredict_tag, rs_if.rob_index_in)))
                    sel = i;
            end
        end
        exp_out  = '0;
        exp_disp = 1'b0;
        if (sel >= 0) begin
            e                 = mq[sel];
            exp_disp          = 1'b1;
            exp_out.valid     = 1'b1;
            exp_out.rob_index = e.tag;
            exp_out.pd        = e.d.pd_new;
            exp_out.ps1       = e.d.ps1;
            exp_out.ps2       = e.d.ps2;
            exp_out.ps1_rdy   = 1'b1;
            exp_out.ps2_rdy   = 1'b1;
            exp_out.fu        = e.d.fu;
            exp_out.payload   = e.d.payload;
            mq.delete(sel);
        end
        if (mispredict) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (is_younger(mq[i].tag, mispredict_tag, rs_if.rob_index_in)) mq.delete(i);
            end
        end
        if (rs_if.di_en && !was_full && !mispredict) begin
            e.tag = rs_if.rob_index_in;
            e.d   = rs_if.r_data;
            e.r1  = tbl[rs_if.r_data.ps1] || (ps_ready && ps_in == rs_if.r_data.ps1);
            e.r2  = tbl[rs_if.r_data.ps2] || (ps_ready && ps_in == rs_if.r_data.ps2);
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd, input logic [4:0] tag);
        rs_if.r_data       = mk(p1, p2, pd);
        rs_if.rob_index_in = tag;
        rs_if.di_en        = 1'b1;
        step();
        rs_if.di_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++; if (rs_if.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", rs_if.full); end
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL reset_disp got=%b exp=0", rs_if.fu_dispatched); end
        checks++; if (rs_if.data_out !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", rs_if.data_out); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mq.delete();
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL reset_idle_disp got=%b exp=0", rs_if.fu_dispatched); end
        $display("test_reset done");
    endtask

    task automatic test_basic_issue();
        tbl[5] = 1'b1; tbl[6] = 1'b1;
        rs_if.fu_ready = 1'b1;
        alloc(7'd5, 7'd6, 7'd20, 5'd3);
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL basic_same_edge got=%b exp=0", rs_if.fu_dispatched); end
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1) begin errors++; $display("FAIL basic_disp got=%b exp=1", rs_if.fu_dispatched); end
        checks++; if (rs_if.data_out.pd !== 7'd20) begin errors++; $display("FAIL basic_pd got=%0d exp=20", rs_if.data_out.pd); end
        checks++; if (rs_if.data_out.rob_index !== 5'd3) begin errors++; $display("FAIL basic_rob got=%0d exp=3", rs_if.data_out.rob_index); end
        checks++; if (rs_if.data_out !== exp_out) begin errors++; $display("FAIL basic_data got=%h exp=%h", rs_if.data_out, exp_out); end
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b0 || rs_if.data_out !== '0) begin
            errors++; $display("FAIL basic_idle got=%b/%h exp=0/0", rs_if.fu_dispatched, rs_if.data_out);
        end
        tbl[5] = 1'b0; tbl[6] = 1'b0;
        $display("test_basic_issue done");
    endtask

    task automatic test_wakeup();
        tbl[6] = 1'b1;
        rs_if.fu_ready = 1'b1;
        alloc(7'd10, 7'd6, 7'd33, 5'd4);
        repeat (2) begin
            step();
            checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL wakeup_early got=%b exp=0", rs_if.fu_dispatched); end
        end
        ps_in = 7'd10; ps_ready = 1'b1;
        step();
        ps_ready = 1'b0;
        checks++; if (rs_if.fu_dispatched !== 1'b1) begin errors++; $display("FAIL wakeup_disp got=%b exp=1", rs_if.fu_dispatched); end
        checks++; if (rs_if.data_out.rob_index !== 5'd4) begin errors++; $display("FAIL wakeup_rob got=%0d exp=4", rs_if.data_out.rob_index); end
        checks++; if (rs_if.data_out !== exp_out) begin errors++; $display("FAIL wakeup_data got=%h exp=%h", rs_if.data_out, exp_out); end
        tbl[6] = 1'b0;
        $display("test_wakeup done");
    endtask

    task automatic test_full();
        rs_if.fu_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rs_if.full !== 1'b0) begin errors++; $display("FAIL fill_full%0d got=%b exp=0", i, rs_if.full); end
            alloc(7'(20 + i), 7'(40 + i), 7'(50 + i), 5'(8 + i));
        end
        checks++; if (rs_if.full !== 1'b1) begin errors++; $display("FAIL full_set got=%b exp=1", rs_if.full); end
        alloc(7'd0, 7'd0, 7'd99, 5'd16);
        checks++; if (rs_if.full !== 1'b1) begin errors++; $display("FAIL full_ignore got=%b exp=1", rs_if.full); end
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL full_nodisp got=%b exp=0", rs_if.fu_dispatched); end
        tbl[43] = 1'b1; ps_in = 7'd23; ps_ready = 1'b1;
        step();
        ps_ready = 1'b0; tbl[43] = 1'b0;
        checks++; if (rs_if.fu_dispatched !== 1'b1 || rs_if.data_out.rob_index !== 5'd11) begin
            errors++; $display("FAIL full_wake3 got=%b/%0d exp=1/11", rs_if.fu_dispatched, rs_if.data_out.rob_index);
        end
        checks++; if (rs_if.full !== 1'b0) begin errors++; $display("FAIL full_clear got=%b exp=0", rs_if.full); end
        alloc(7'd30, 7'd31, 7'd60, 5'd16);
        checks++; if (rs_if.full !== 1'b1) begin errors++; $display("FAIL full_reuse got=%b exp=1", rs_if.full); end
        mispredict = 1'b1; mispredict_tag = 5'd7; rs_if.rob_index_in = 5'd17;
        step();
        mispredict = 1'b0;
        checks++; if (rs_if.full !== 1'b0) begin errors++; $display("FAIL full_flush got=%b exp=0", rs_if.full); end
        for (int p = 20; p < 48; p++) tbl[p] = 1'b1;
        step();
        checks++; if (rs_if.fu_dispatched !== exp_disp) begin errors++; $display("FAIL full_empty got=%b exp=%b", rs_if.fu_dispatched, exp_disp); end
        for (int p = 20; p < 48; p++) tbl[p] = 1'b0;
        $display("test_full done");
    endtask

    task automatic test_wrap_flush();
        logic [4:0] tags [4];
        tags[0] = 5'd30; tags[1] = 5'd31; tags[2] = 5'd0; tags[3] = 5'd1;
        rs_if.fu_ready = 1'b0;
        for (int k = 0; k < 4; k++) alloc(7'(60 + k), 7'(70 + k), 7'(k + 1), tags[k]);
        tbl[0] = 1'b1;
        rs_if.r_data = mk(7'd0, 7'd0, 7'd77);
        rs_if.di_en = 1'b1;
        mispredict = 1'b1; mispredict_tag = 5'd31; rs_if.rob_index_in = 5'd2;
        step();
        mispredict = 1'b0; rs_if.di_en = 1'b0;
        for (int k = 0; k < 4; k++) begin tbl[60 + k] = 1'b1; tbl[70 + k] = 1'b1; end
        rs_if.fu_ready = 1'b1;
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1 || rs_if.data_out.rob_index !== 5'd30) begin
            errors++; $display("FAIL wrap_first got=%b/%0d exp=1/30", rs_if.fu_dispatched, rs_if.data_out.rob_index);
        end
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1 || rs_if.data_out.rob_index !== 5'd31) begin
            errors++; $display("FAIL wrap_second got=%b/%0d exp=1/31", rs_if.fu_dispatched, rs_if.data_out.rob_index);
        end
        checks++; if (rs_if.data_out !== exp_out) begin errors++; $display("FAIL wrap_data got=%h exp=%h", rs_if.data_out, exp_out); end
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL wrap_flushed got=%b exp=0", rs_if.fu_dispatched); end
        for (int k = 0; k < 4; k++) begin tbl[60 + k] = 1'b0; tbl[70 + k] = 1'b0; end
        $display("test_wrap_flush done");
    endtask

    task automatic test_age_order();
        rs_if.fu_ready = 1'b0;
        alloc(7'd0, 7'd0, 7'd11, 5'd3);
        alloc(7'd86, 7'd87, 7'd12, 5'd4);
        rs_if.fu_ready = 1'b1;
        step();
        checks++; if (rs_if.data_out.rob_index !== 5'd3) begin errors++; $display("FAIL age_pre got=%0d exp=3", rs_if.data_out.rob_index); end
        rs_if.fu_ready = 1'b0;
        alloc(7'd88, 7'd89, 7'd13, 5'd7);
        for (int p = 86; p < 90; p++) tbl[p] = 1'b1;
        rs_if.fu_ready = 1'b1;
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1 || rs_if.data_out.rob_index !== 5'd4) begin
            errors++; $display("FAIL age_first got=%b/%0d exp=1/4", rs_if.fu_dispatched, rs_if.data_out.rob_index);
        end
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1 || rs_if.data_out.rob_index !== 5'd7) begin
            errors++; $display("FAIL age_second got=%b/%0d exp=1/7", rs_if.fu_dispatched, rs_if.data_out.rob_index);
        end
        checks++; if (rs_if.data_out !== exp_out) begin errors++; $display("FAIL age_data got=%h exp=%h", rs_if.data_out, exp_out); end
        for (int p = 86; p < 90; p++) tbl[p] = 1'b0;
        $display("test_age_order done");
    endtask

    task automatic test_reset_midrun();
        rs_if.fu_ready = 1'b0;
        for (int k = 0; k < 3; k++) alloc(7'(90 + k), 7'(100 + k), 7'(k + 40), 5'(20 + k));
        tbl[0] = 1'b1;
        rs_if.fu_ready = 1'b1;
        alloc(7'd0, 7'd0, 7'd44, 5'd23);
        step();
        checks++; if (rs_if.fu_dispatched !== 1'b1) begin errors++; $display("FAIL midrun_pre got=%b exp=1", rs_if.fu_dispatched); end
        #2 reset = 1'b0;
        mq.delete();
        #1;
        checks++; if (rs_if.full !== 1'b0) begin errors++; $display("FAIL midrun_full got=%b exp=0", rs_if.full); end
        checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL midrun_disp got=%b exp=0", rs_if.fu_dispatched); end
        checks++; if (rs_if.data_out !== '0) begin errors++; $display("FAIL midrun_data got=%h exp=0", rs_if.data_out); end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int p = 90; p < 103; p++) tbl[p] = 1'b1;
        repeat (3) begin
            step();
            checks++; if (rs_if.fu_dispatched !== 1'b0) begin errors++; $display("FAIL midrun_after got=%b exp=0", rs_if.fu_dispatched); end
        end
        for (int p = 90; p < 103; p++) tbl[p] = 1'b0;
        tbl[0] = 1'b0;
        $display("test_reset_midrun done");
    endtask

    task automatic test_random();
        logic [4:0] tail;
        bit         did_alloc;
        int         bad;
        tail = 5'd0;
        bad  = 0;
        for (int c = 0; c < 400; c++) begin
            rs_if.fu_ready = ($urandom_range(0, 3) != 0);
            ps_ready       = 1'($urandom_range(0, 1));
            ps_in          = 7'($urandom_range(0, 15));
            tbl[$urandom_range(0, 15)] = 1'($urandom_range(0, 1));
            mispredict     = ($urandom_range(0, 19) == 0) && (mq.size() > 0);
            if (mispredict) mispredict_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
            rs_if.rob_index_in = tail;
            rs_if.di_en        = 1'($urandom_range(0, 1));
            rs_if.r_data       = mk(7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 7'($urandom));
            did_alloc = rs_if.di_en && (mq.size() < DEPTH) && !mispredict;
            checks++; if (rs_if.full !== (mq.size() == DEPTH)) begin
                errors++; bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", c, rs_if.full, mq.size() == DEPTH);
            end
            step();
            checks++; if (rs_if.fu_dispatched !== exp_disp) begin
                errors++; bad++; $display("FAIL rand_disp cyc=%0d got=%b exp=%b", c, rs_if.fu_dispatched, exp_disp);
            end
            checks++; if (rs_if.data_out !== exp_out) begin
                errors++; bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, rs_if.data_out, exp_out);
            end
            if (mispredict) tail = mispredict_tag + 5'd1;
            else if (did_alloc) tail = tail + 5'd1;
        end
        rs_if.di_en = 1'b0; mispredict = 1'b0; ps_ready = 1'b0;
        $display("test_random done bad=%0d", bad);
    endtask

    initial begin
        for (int p = 0; p < 128; p++) tbl[p] = 1'b0;
        rs_if.di_en        = 1'b0;
        rs_if.fu_ready     = 1'b0;
        rs_if.rob_index_in = '0;
        rs_if.r_data       = '0;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_wrap_flush();
        test_age_order();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
